// File: rtl/qsn_pkg.sv
// Shared constants, plane type and rotation helper for the Z=3 quasi-cyclic
// shift network and its return-path de-shifter.
package qsn_pkg;

  localparam int Z       = 3;
  localparam int QUAN    = 4;
  localparam int SHIFT_W = 2;
  localparam int DEPTH   = 8;

  typedef logic [Z-1:0] plane_t;

  // Undo a forward left-circular shift: out[j] = in[(j - s) mod Z].
  // Bits move towards higher indices; s outside 0..Z-1 is treated as 0.
  function automatic plane_t rotate_right(input plane_t p, input logic [SHIFT_W-1:0] s);
    plane_t r;
    case (s)
      2'd1:    r = {p[1:0], p[2]};
      2'd2:    r = {p[0], p[2:1]};
      default: r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/qsn_shift_fifo.sv
// Synchronous FIFO of shift factors issued to the forward network.
// Illegal factors (>= Z) are stored as 0 and raise a sticky error flag.
module qsn_shift_fifo #(
  parameter int DEPTH   = qsn_pkg::DEPTH,
  parameter int SHIFT_W = qsn_pkg::SHIFT_W,
  parameter int Z       = qsn_pkg::Z
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [SHIFT_W-1:0]       wr_data,
  input  logic                     rd_en,
  output logic [SHIFT_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SHIFT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               push, pop, illegal;
  logic [SHIFT_W-1:0] wr_clamped;

  // Full/empty come from the registered count only, so a pop never frees
  // a slot for a push in the same cycle and there is no write-to-read bypass.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = wr_en && !full;
  assign pop        = rd_en && !empty;
  assign illegal    = ({1'b0, wr_data} >= (SHIFT_W+1)'(Z));
  assign wr_clamped = illegal ? '0 : wr_data;

  // Pointer, occupancy and error-flag next state; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push && illegal) err_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    err_q    <= err_d;
  end

  // Factor storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wr_clamped;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign err     = err_q;

endmodule

// File: rtl/qsn_deshift_len3.sv
// Return-path inverse of the Z=3 quasi-cyclic shift network: pairs each
// returning message with its recorded shift factor and rotates it back.
module qsn_deshift_len3 #(
  parameter int Z       = qsn_pkg::Z,
  parameter int QUAN    = qsn_pkg::QUAN,
  parameter int SHIFT_W = qsn_pkg::SHIFT_W,
  parameter int DEPTH   = qsn_pkg::DEPTH
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   fwd_shift_valid,
  input  logic [SHIFT_W-1:0]     fwd_shift,
  output logic                   fwd_shift_ready,
  input  logic                   ret_valid,
  input  logic [Z-1:0]           ret_bit0,
  input  logic [Z-1:0]           ret_bit1,
  input  logic [Z-1:0]           ret_bit2,
  input  logic [Z-1:0]           ret_bit3,
  output logic                   ret_ready,
  output logic                   out_valid,
  output logic [Z-1:0]           out_bit0,
  output logic [Z-1:0]           out_bit1,
  output logic [Z-1:0]           out_bit2,
  output logic [Z-1:0]           out_bit3,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   shift_err
);

  import qsn_pkg::*;

  logic               clr;
  logic               fifo_full, fifo_empty, accept;
  logic [SHIFT_W-1:0] head_s;

  logic [QUAN-1:0][Z-1:0] ret_pl;
  logic [QUAN-1:0][Z-1:0] out_pl;

  logic               vld_p1_q, vld_p1_d;
  logic [SHIFT_W-1:0] s_p1_q, s_p1_d;
  logic               vld_p2_q, vld_p2_d;

  assign clr             = rst | flush;
  assign fwd_shift_ready = !fifo_full;
  assign ret_ready       = !fifo_empty;
  assign accept          = ret_valid && !fifo_empty;
  assign ret_pl          = {ret_bit3, ret_bit2, ret_bit1, ret_bit0};

  qsn_shift_fifo #(
    .DEPTH   (DEPTH),
    .SHIFT_W (SHIFT_W),
    .Z       (Z)
  ) u_fifo (
    .clk     (sys_clk),
    .clr     (clr),
    .wr_en   (fwd_shift_valid),
    .wr_data (fwd_shift),
    .rd_en   (ret_valid),
    .rd_data (head_s),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .err     (shift_err)
  );

  // Pipeline control: stage 1 captures the accepted message's factor,
  // stage 2 just follows stage 1's valid.
  always_comb begin
    vld_p1_d = accept;
    s_p1_d   = accept ? head_s : s_p1_q;
    vld_p2_d = vld_p1_q;
  end

  // Stage valids clear on reset or flush; the factor is data and is not reset.
  always_ff @(posedge sys_clk) begin
    if (rst || flush) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
    s_p1_q <= s_p1_d;
  end

  for (genvar k = 0; k < QUAN; k++) begin : g_plane
    logic [Z-1:0] pl_p1_q, pl_p1_d;
    logic [Z-1:0] pl_p2_q, pl_p2_d;

    // Stage 1 captures the shifted plane; stage 2 loads the de-rotated plane
    // only for a live message, so outputs hold across idle cycles and flushes.
    always_comb begin
      pl_p1_d = accept ? ret_pl[k] : pl_p1_q;
      pl_p2_d = (vld_p1_q && !clr) ? rotate_right(pl_p1_q, s_p1_q) : pl_p2_q;
    end

    // Stage 1 plane register.
    always_ff @(posedge sys_clk) begin
      pl_p1_q <= pl_p1_d;
    end

    // Stage 2 plane register; visible output, so reset to zero.
    always_ff @(posedge sys_clk) begin
      if (rst) pl_p2_q <= '0;
      else     pl_p2_q <= pl_p2_d;
    end

    assign out_pl[k] = pl_p2_q;
  end

  assign out_valid = vld_p2_q;
  assign out_bit0  = out_pl[0];
  assign out_bit1  = out_pl[1];
  assign out_bit2  = out_pl[2];
  assign out_bit3  = out_pl[3];

endmodule

// File: tb/tb_qsn_deshift_len3.sv
// Scoreboard bench for qsn_deshift_len3 with a queue-based reference model.
module tb_qsn_deshift_len3;

  logic       sys_clk = 1'b0;
  logic       rst, flush;
  logic       fwd_shift_valid;
  logic [1:0] fwd_shift;
  logic       fwd_shift_ready;
  logic       ret_valid;
  logic [2:0] ret_bit0, ret_bit1, ret_bit2, ret_bit3;
  logic       ret_ready;
  logic       out_valid;
  logic [2:0] out_bit0, out_bit1, out_bit2, out_bit3;
  logic [3:0] fifo_count;
  logic       shift_err;

  always #5 sys_clk = ~sys_clk;

  qsn_deshift_len3 dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .flush           (flush),
    .fwd_shift_valid (fwd_shift_valid),
    .fwd_shift       (fwd_shift),
    .fwd_shift_ready (fwd_shift_ready),
    .ret_valid       (ret_valid),
    .ret_bit0        (ret_bit0),
    .ret_bit1        (ret_bit1),
    .ret_bit2        (ret_bit2),
    .ret_bit3        (ret_bit3),
    .ret_ready       (ret_ready),
    .out_valid       (out_valid),
    .out_bit0        (out_bit0),
    .out_bit1        (out_bit1),
    .out_bit2        (out_bit2),
    .out_bit3        (out_bit3),
    .fifo_count      (fifo_count),
    .shift_err       (shift_err)
  );

  typedef struct {
    int          due;
    logic [11:0] pl;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          started = 0;
  int          sq[$];
  exp_t        eq[$];
  logic        model_err;
  logic [11:0] last_out;
  exp_t        mon_e;
  logic [11:0] mon_got;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference de-rotation straight from out[j] = in[(j - s) mod 3], per plane.
  function automatic logic [11:0] inv_rot(input logic [11:0] p, input int s);
    logic [11:0] r;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++)
        r[k*3+j] = p[k*3 + ((j - s + 3) % 3)];
    return r;
  endfunction

  // Drive one cycle of inputs, check control outputs against the model, then
  // advance the model to the state after the coming clock edge.
  task automatic step(input logic fv, input logic [1:0] fs, input logic rv,
                      input logic [11:0] pl, input logic r, input logic fl);
    logic acc, psh;
    int   s;
    @(negedge sys_clk);
    fwd_shift_valid = fv;
    fwd_shift       = fs;
    ret_valid       = rv;
    {ret_bit3, ret_bit2, ret_bit1, ret_bit0} = pl;
    rst             = r;
    flush           = fl;
    #1;
    chk("fwd_shift_ready", fwd_shift_ready, sq.size() != 8);
    chk("ret_ready", ret_ready, sq.size() != 0);
    chk("fifo_count", fifo_count, sq.size());
    chk("shift_err", shift_err, model_err);
    if (r || fl) begin
      sq.delete();
      eq.delete();
      model_err = 1'b0;
      if (r) last_out = '0;
    end else begin
      acc = rv && (sq.size() != 0);
      psh = fv && (sq.size() != 8);
      if (acc) begin
        s = sq.pop_front();
        eq.push_back('{cyc + 2, inv_rot(pl, s)});
      end
      if (psh) begin
        if (fs >= 2'd3) begin
          sq.push_back(0);
          model_err = 1'b1;
        end else begin
          sq.push_back(int'(fs));
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 12'($urandom), 1'b0, 1'b0);
  endtask

  task automatic push(input logic [1:0] fs);
    step(1'b1, fs, 1'b0, 12'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send(input logic [11:0] pl);
    step(1'b0, 2'd0, 1'b1, pl, 1'b0, 1'b0);
  endtask

  // Monitor: every presented output must match the oldest expected message,
  // at the expected cycle; otherwise the output planes must hold.
  always @(negedge sys_clk) begin
    if (started) begin
      mon_got = {out_bit3, out_bit2, out_bit1, out_bit0};
      if (out_valid !== 1'b0) begin
        if (eq.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_e = eq.pop_front();
          chk("out_latency", cyc, mon_e.due);
          chk("out_data", mon_got, mon_e.pl);
          last_out = mon_e.pl;
        end
      end else begin
        chk("out_hold", mon_got, last_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    fwd_shift_valid = 1'b0; fwd_shift = '0; ret_valid = 1'b0;
    ret_bit0 = '0; ret_bit1 = '0; ret_bit2 = '0; ret_bit3 = '0;
    model_err = 1'b0;
    last_out  = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_bits", {out_bit3, out_bit2, out_bit1, out_bit0}, 12'h000);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("reset_fwd_ready", 32'(fwd_shift_ready), 32'd1);
    chk("reset_ret_ready", 32'(ret_ready), 32'd0);
    chk("reset_shift_err", 32'(shift_err), 32'd0);
    started = 1;

    // Basic inverse: s=1 moves 001 to 010, s=0 passes 001 through.
    push(2'd1);
    push(2'd0);
    send(12'h001);
    send(12'h001);
    repeat (3) idle();

    // Round trip with s=2 across four distinct planes.
    push(2'd2);
    send({3'b110, 3'b011, 3'b101, 3'b100});
    repeat (3) idle();

    // Full: 8 pushes fill the FIFO, the 9th is refused.
    for (int i = 0; i < 9; i++) push(2'($urandom_range(0, 2)));
    for (int i = 0; i < 8; i++) send(12'($urandom));
    repeat (2) idle();

    // Empty: held return data waits for a push, accepted the cycle after.
    for (int i = 0; i < 3; i++) send(12'h5a3);
    step(1'b1, 2'd2, 1'b1, 12'h5a3, 1'b0, 1'b0);
    send(12'h5a3);
    repeat (3) idle();

    // Simultaneous push/pop at depth 4 across pointer wrap-around.
    for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 2)));
    for (int i = 0; i < 10; i++)
      step(1'b1, 2'($urandom_range(0, 2)), 1'b1, 12'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(12'($urandom));
    repeat (3) idle();

    // Illegal factor is stored as 0; flush clears the flag and the FIFO.
    push(2'd3);
    send(12'hb6d);
    push(2'd1);
    push(2'd2);
    idle();
    step(1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 1'b1);
    repeat (3) idle();

    // Reset mid-stream discards the FIFO and the in-flight message.
    push(2'd1);
    push(2'd2);
    push(2'd0);
    send(12'h9c4);
    step(1'b0, 2'd0, 1'b0, 12'h000, 1'b1, 1'b0);
    repeat (4) idle();

    // Randomized traffic with occasional illegal factors, flushes and resets.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 2) != 0),
           12'($urandom),
           1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 49) == 0));

    for (int i = 0; i < 10; i++) send(12'($urandom));
    repeat (4) idle();
    chk("scoreboard_drained", eq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
